// File: rtl/spram_arbiter.sv
// spram_arbiter: two-requester arbiter in front of a single-port RAM with one-cycle read latency
module spram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wrdata,
    input  logic          m0_cyc,
    input  logic          m0_write,
    output logic [DW-1:0] m0_rddata,
    output logic          m0_ack,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wrdata,
    input  logic          m1_cyc,
    input  logic          m1_write,
    output logic [DW-1:0] m1_rddata,
    output logic          m1_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_wren,
    output logic          ram_cs,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    gnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    state_t state, state_n;
    logic sel, sel_n, last, last_n;
    logic other_cyc, in_access, in_ack;
    assign other_cyc = sel ? m0_cyc : m1_cyc;
    assign in_access = state == ACCESS;
    assign in_ack    = state == ACK;
    // state, owner and last-served registers; last=1 on reset so m0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            last  <= last_n;
        end
    end
    // next-state: arbitrate in IDLE, hand straight over to a waiting peer in ACK
    always_comb begin
        state_n = state;
        sel_n   = sel;
        last_n  = last;
        case (state)
            IDLE: begin
                state_n = (m0_cyc || m1_cyc) ? ACCESS : IDLE;
                sel_n   = (m0_cyc && m1_cyc) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last) : (m0_cyc ? 1'b0 : (m1_cyc ? 1'b1 : sel));
            end
            ACCESS: state_n = ACK;
            ACK: begin
                last_n  = sel;
                state_n = other_cyc ? ACCESS : IDLE;
                sel_n   = other_cyc ? ~sel : sel;
            end
            default: state_n = IDLE;
        endcase
    end
    assign ram_cs    = in_access;
    assign ram_wren  = in_access && (sel ? m1_write : m0_write);
    assign ram_addr  = in_access ? (sel ? m1_addr : m0_addr) : '0;
    assign ram_din   = in_access ? (sel ? m1_wrdata : m0_wrdata) : '0;
    assign gnt       = in_access ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign m0_ack    = in_ack && !sel;
    assign m1_ack    = in_ack && sel;
    assign m0_rddata = m0_ack ? ram_dout : '0;
    assign m1_rddata = m1_ack ? ram_dout : '0;
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: round-robin and fixed-priority arbiters driven side by side against a reference model
module tb_spram_arbiter;
    localparam int AW = 14;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wrdata = '0, m1_wrdata = '0;
    logic m0_cyc = 1'b0, m0_write = 1'b0, m1_cyc = 1'b0, m1_write = 1'b0;
    logic [DW-1:0] m0_rddata[2], m1_rddata[2], ram_din[2];
    logic [DW-1:0] ram_dout[2] = '{default: '0};
    logic m0_ack[2], m1_ack[2], ram_wren[2], ram_cs[2];
    logic [AW-1:0] ram_addr[2];
    logic [1:0] gnt[2];
    logic [DW-1:0] mem[2][1<<AW];
    logic pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int n_chk = 0, n_fail = 0;
    // model: phase 0 = nobody on the RAM, 1 = RAM slot of owner, 2 = reply to owner
    int ph[2] = '{0, 0};
    int own[2] = '{0, 0};
    int lst[2] = '{1, 1};
    int seq0[$], seq1[$];

    always #5 clk = ~clk;

    spram_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_cyc(m0_cyc), .m0_write(m0_write),
        .m0_rddata(m0_rddata[0]), .m0_ack(m0_ack[0]),
        .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_cyc(m1_cyc), .m1_write(m1_write),
        .m1_rddata(m1_rddata[0]), .m1_ack(m1_ack[0]),
        .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_wren(ram_wren[0]), .ram_cs(ram_cs[0]),
        .ram_dout(ram_dout[0]), .gnt(gnt[0])
    );
    spram_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_cyc(m0_cyc), .m0_write(m0_write),
        .m0_rddata(m0_rddata[1]), .m0_ack(m0_ack[1]),
        .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_cyc(m1_cyc), .m1_write(m1_write),
        .m1_rddata(m1_rddata[1]), .m1_ack(m1_ack[1]),
        .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_wren(ram_wren[1]), .ram_cs(ram_cs[1]),
        .ram_dout(ram_dout[1]), .gnt(gnt[1])
    );

    // one SPRAM per arbiter, read data one cycle after chip select
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (pre_en) mem[p][pre_addr] <= pre_data;
            if (ram_cs[p]) begin
                if (ram_wren[p]) mem[p][ram_addr[p]] <= ram_din[p];
                else ram_dout[p] <= mem[p][ram_addr[p]];
            end
        end
    end

    // reference model of who owns the RAM and when replies happen
    always @(posedge clk or posedge rst) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                ph[p] <= 0;
                own[p] <= 0;
                lst[p] <= 1;
            end else if (ph[p] == 0) begin
                if (m0_cyc || m1_cyc) begin
                    ph[p] <= 1;
                    own[p] <= (m0_cyc && m1_cyc) ? ((p == 1) ? 0 : 1 - lst[p]) : (m0_cyc ? 0 : 1);
                end
            end else if (ph[p] == 1) begin
                ph[p] <= 2;
            end else begin
                lst[p] <= own[p];
                if ((own[p] == 0) ? m1_cyc : m0_cyc) begin
                    own[p] <= 1 - own[p];
                    ph[p] <= 1;
                end else begin
                    ph[p] <= 0;
                end
            end
        end
    end

    function automatic logic [67:0] expv(int p);
        logic a, k, o, ack0, ack1;
        a = ph[p] == 1;
        k = ph[p] == 2;
        o = own[p] == 1;
        ack0 = k && !o;
        ack1 = k && o;
        return {a ? (o ? 2'b10 : 2'b01) : 2'b00, a, a && (o ? m1_write : m0_write),
                a ? (o ? m1_addr : m0_addr) : 14'h0, a ? (o ? m1_wrdata : m0_wrdata) : 16'h0,
                ack0, ack0 ? ram_dout[p] : 16'h0, ack1, ack1 ? ram_dout[p] : 16'h0};
    endfunction

    function automatic logic [67:0] actv(int p);
        return {gnt[p], ram_cs[p], ram_wren[p], ram_addr[p], ram_din[p],
                m0_ack[p], m0_rddata[p], m1_ack[p], m1_rddata[p]};
    endfunction

    // every-cycle comparison of both arbiters against the model
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            n_chk++;
            if (actv(p) !== expv(p)) begin
                n_fail++;
                $display("FAIL model_p%0d t=%0t got %h expected %h", p, $time, actv(p), expv(p));
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic nedge;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        pre_en = 1'b1;
        pre_addr = 14'h0123;
        pre_data = 16'hBEEF;
        step;
        pre_en = 1'b0;
        nedge;
        chk("rst_out", {gnt[0], ram_cs[0], m0_ack[0], m1_ack[0], gnt[1], ram_cs[1]}, 0);
        // single read by m0
        step;
        rst = 1'b0;
        m0_addr = 14'h0123;
        m0_write = 1'b0;
        m0_cyc = 1'b1;
        nedge;
        chk("t1_idle_cs", ram_cs[0], 0);
        nedge;
        chk("t1_cs", {ram_cs[0], ram_addr[0]}, {1'b1, 14'h0123});
        chk("t1_gnt", gnt[0], 2'b01);
        nedge;
        chk("t1_ack", {m0_ack[0], m1_ack[0], ram_cs[0]}, 3'b100);
        chk("t1_rd", m0_rddata[0], 16'hBEEF);
        step;
        m0_cyc = 1'b0;
        // m1 write then read back
        step;
        m1_addr = 14'h3FFF;
        m1_wrdata = 16'h5A5A;
        m1_write = 1'b1;
        m1_cyc = 1'b1;
        nedge;
        nedge;
        chk("t2_wr", {ram_cs[0], ram_wren[0], ram_addr[0], ram_din[0]}, {1'b1, 1'b1, 14'h3FFF, 16'h5A5A});
        chk("t2_gnt", gnt[0], 2'b10);
        nedge;
        chk("t2_wack", {m1_ack[0], m0_ack[0]}, 2'b10);
        step;
        m1_cyc = 1'b0;
        step;
        m1_write = 1'b0;
        m1_cyc = 1'b1;
        nedge;
        nedge;
        chk("t2_rdcs", {ram_cs[0], ram_wren[0]}, 2'b10);
        nedge;
        chk("t2_rd", {m1_ack[0], m1_rddata[0]}, {1'b1, 16'h5A5A});
        chk("t2_m0rd", m0_rddata[0], 0);
        step;
        m1_cyc = 1'b0;
        // tie right after reset
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        m0_addr = 14'h0001;
        m1_addr = 14'h0002;
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        nedge;
        nedge;
        chk("t3_gnt_first", {gnt[0], gnt[1]}, 4'b0101);
        nedge;
        chk("t3_ack_m0", {m0_ack[0], m1_ack[0]}, 2'b10);
        step;
        m0_cyc = 1'b0;
        nedge;
        chk("t3_gnt_second", {gnt[0], gnt[1]}, 4'b1010);
        nedge;
        chk("t3_ack_m1", {m0_ack[0], m1_ack[0]}, 2'b01);
        step;
        m1_cyc = 1'b0;
        // sustained contention, both policies must alternate
        step;
        m0_addr = 14'h0010;
        m1_addr = 14'h0020;
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        for (int c = 0; c < 40 && (seq0.size() < 8 || seq1.size() < 8); c++) begin
            nedge;
            if (m0_ack[0]) seq0.push_back(0);
            if (m1_ack[0]) seq0.push_back(1);
            if (m0_ack[1]) seq1.push_back(0);
            if (m1_ack[1]) seq1.push_back(1);
        end
        chk("t4_count", {seq0.size() >= 8, seq1.size() >= 8}, 2'b11);
        for (int i = 0; i < 8; i++) begin
            if (i < seq0.size()) chk($sformatf("t4_rr_%0d", i), seq0[i], i % 2);
            if (i < seq1.size()) chk($sformatf("t4_fp_%0d", i), seq1[i], i % 2);
        end
        step;
        m0_cyc = 1'b0;
        m1_cyc = 1'b0;
        repeat (6) nedge;
        // m0 served last, then a tie separates the two policies
        step;
        m0_addr = 14'h0123;
        m0_cyc = 1'b1;
        repeat (3) nedge;
        step;
        m0_cyc = 1'b0;
        step;
        m1_addr = 14'h3FFF;
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        nedge;
        nedge;
        chk("t5_rr_gnt", gnt[0], 2'b10);
        chk("t5_fp_gnt", gnt[1], 2'b01);
        nedge;
        chk("t5_rr_ack", {m1_ack[0], m1_rddata[0]}, {1'b1, 16'h5A5A});
        chk("t5_fp_ack", {m0_ack[1], m0_rddata[1]}, {1'b1, 16'hBEEF});
        step;
        m0_cyc = 1'b0;
        m1_cyc = 1'b0;
        repeat (6) nedge;
        // reset in the middle of an access
        step;
        m0_addr = 14'h0123;
        m0_cyc = 1'b1;
        nedge;
        nedge;
        chk("t6_cs", ram_cs[0], 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_cs_drop", {ram_cs[0], ram_cs[1], gnt[0], gnt[1]}, 0);
        m1_cyc = 1'b1;
        nedge;
        chk("t6_no_ack", {m0_ack[0], m1_ack[0], m0_ack[1], m1_ack[1]}, 0);
        step;
        rst = 1'b0;
        nedge;
        chk("t6_idle", gnt[0], 0);
        nedge;
        chk("t6_gnt", {gnt[0], gnt[1]}, 4'b0101);
        nedge;
        chk("t6_ack", {m0_ack[0], m0_rddata[0]}, {1'b1, 16'hBEEF});
        step;
        m0_cyc = 1'b0;
        nedge;
        chk("t6_gnt_m1", gnt[0], 2'b10);
        nedge;
        chk("t6_ack_m1", {m1_ack[0], m1_rddata[0]}, {1'b1, 16'h5A5A});
        step;
        m1_cyc = 1'b0;
        repeat (4) nedge;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 14, giving the word-address width.
REQ-002 The block SHALL have parameter DW, default 16, giving the data width.
REQ-003 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin; 1 = m0 always wins ties.
REQ-004 The block SHALL have one clock, clk, and reset, rst; rst is asynchronous and active-high.
REQ-005 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  async active-high reset
- m0_addr  in  AW  requester 0 address
- m0_wrdata  in  DW  requester 0 write data
- m0_cyc  in  1  requester 0 request
- m0_write  in  1  requester 0 write (1) / read (0)
- m0_rddata  out  DW  requester 0 read data
- m0_ack  out  1  requester 0 completion strobe
- m1_addr, m1_wrdata, m1_cyc, m1_write, m1_rddata, m1_ack  same as m0_*, for requester 1
- ram_addr  out  AW  SPRAM address
- ram_din  out  DW  SPRAM write data
- ram_wren  out  1  SPRAM write enable
- ram_cs  out  1  SPRAM chip select
- ram_dout  in  DW  SPRAM read data, valid one cycle after ram_cs
- gnt  out  2  one-hot owner of the current access; 00 = none

Function
REQ-006 Requester protocol SHALL be: assert mN_cyc and hold mN_addr/mN_wrdata/mN_write stable until mN_ack; mN_ack is a single-cycle strobe.
REQ-007 The FSM SHALL have states IDLE, ACCESS, ACK and a registered owner bit sel plus a registered last-served bit last.
REQ-008 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-009 In IDLE with exactly one mN_cyc high, the FSM SHALL set sel=N and go to ACCESS.
REQ-010 In IDLE with both requests high, the FSM SHALL select m0 if FIXED_PRIO=1; otherwise it SHALL select the requester not equal to last.
REQ-011 In ACCESS, the FSM SHALL drive ram_cs=1, ram_addr/ram_din/ram_wren from the selected requester's addr/wrdata/write, and gnt[sel]=1; it SHALL go to ACK unconditionally.
REQ-012 In ACK, the FSM SHALL pulse m<sel>_ack=1, drive m<sel>_rddata=ram_dout (for writes as well; the value is don't-care to the requester), update last=sel, and keep ram_cs=0.
REQ-013 In ACK, the selected requester's cyc SHALL be ignored; if the other requester's cyc is high, the FSM SHALL go to ACCESS with sel flipped; otherwise it SHALL go to IDLE.
REQ-014 Latency SHALL be 2 cycles from mN_cyc sampled in IDLE to mN_ack; a single requester SHALL see one access per 3 cycles; two alternating requesters SHALL get one access per 2 cycles.
REQ-015 Outside ACCESS, ram_cs, ram_wren, ram_addr and ram_din SHALL be 0.
REQ-016 Outside ACK, both mN_ack SHALL be 0 and both mN_rddata SHALL be 0; the non-selected requester's rddata SHALL be 0 in ACK.
REQ-017 Exactly one ram_cs cycle SHALL occur per ack, and at most one mN_ack SHALL be high per cycle.
REQ-018 gnt SHALL be 00 in IDLE and ACK.
REQ-019 A requester dropping cyc before ack (protocol violation) SHALL NOT corrupt the FSM; the access completes and the ack SHALL still be issued.

Reset
REQ-020 rst high SHALL immediately force state=IDLE, sel=0, last=1, so that m0 wins the first tie.
REQ-021 During reset, all outputs SHALL be 0.
REQ-022 Reset during ACCESS or ACK SHALL abort the access with no ack issued; the requester must retry.
REQ-023 After rst deasserts, the first arbitration decision SHALL be made on the first rising edge.

Verification
REQ-024 Single read: m0 reads addr 0x0123 with ram_dout=0xBEEF -> ram_cs high for 1 cycle at 0x0123, m0_ack 2 cycles after request with m0_rddata=0xBEEF, m1_ack stays 0.
REQ-025 Write then read: m1 writes 0x5A5A to 0x3FFF -> ram_wren=1 and ram_din=0x5A5A in ACCESS; then m1 reads 0x3FFF -> m1_rddata=0x5A5A.
REQ-026 Tie after reset: m0_cyc and m1_cyc rise together -> m0 served first, m1 served immediately after with no IDLE cycle; acks 2 cycles apart.
REQ-027 Sustained contention, round-robin: both requesters hold cyc continuously for 8 accesses -> grants strictly alternate m0,m1,m0,...; with FIXED_PRIO=1 and the same stimulus, m1 is still served after each m0 access (per REQ-013).
REQ-028 Async reset mid-access: assert rst in ACCESS -> ram_cs drops in the same cycle, no ack; after release, the held request completes normally with m0 winning any tie.
